// File: rtl/zipo_fetch_pkg.sv
// Shared constants, state encodings and helpers for the zipo_fetch slice.
// Optional performance counters are enabled with the ZIPO_FETCH_PERF_EN macro.
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0000_0000_0000_0040
`endif

package zipo_fetch_pkg;

    localparam logic [63:0] ZF_INITIAL_PC       = `INITIAL_PC;
    localparam int          FETCH_DEPTH_DEFAULT = 4;
    localparam logic [63:0] FETCH_PC_STEP       = 64'd1;

    localparam logic FETCH_ST_RUN   = 1'b0;
    localparam logic FETCH_ST_DRAIN = 1'b1;

    typedef enum logic {
        ST_RUN   = FETCH_ST_RUN,
        ST_DRAIN = FETCH_ST_DRAIN
    } fetch_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/zipo_fetch_if.sv
// Request/response/instruction channels between fetch, instruction memory and core.
// The fetch stage uses the master modport; memory and core sit on the slave side.
interface zipo_fetch_if;

    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, instr_ready,
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, instr_ready,
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/zipo_fetch_chk.sv
// Protocol checker for the prefetch FIFO; holds assertions only, no functional logic.
module zipo_fetch_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);

    // Credits must make it impossible to push into a full FIFO that is not popping.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/zipo_fetch_fifo.sv
// Synchronous prefetch FIFO with clear; head word is read straight from storage flops.
// Push on full is accepted only when a pop frees the slot in the same cycle.
module zipo_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/zipo_fetch.sv
// Instruction fetch stage: credit-limited requests, prefetch FIFO, redirect flush/drain.
// Define ZIPO_FETCH_PERF_EN to add saturating stall and flush counters.
module zipo_fetch
    import zipo_fetch_pkg::*;
#(
    parameter logic [63:0] INITIAL_PC = ZF_INITIAL_PC,
    parameter int          DEPTH      = FETCH_DEPTH_DEFAULT,
    parameter logic [63:0] PC_STEP    = FETCH_PC_STEP
) (
    input logic          clk,
    input logic          rst_n,
    zipo_fetch_if.master bus
`ifdef ZIPO_FETCH_PERF_EN
    ,
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_flush_cnt
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_e   state_r, state_nxt_s;
    logic [63:0]    fetch_pc_r, head_pc_r;
    logic [CW-1:0]  outstanding_r, outstanding_nxt_s;
    logic [CW-1:0]  drop_cnt_r, drop_nxt_s;
    logic [CW-1:0]  fifo_count_s;
    logic [CW-1:0]  rsp_one_s, req_one_s;
    logic [CW:0]    credit_sum_s;
    logic           req_valid_s, req_fire_s, push_s, pop_s;
    logic           fifo_full_s, fifo_empty_s;
    logic [31:0]    fifo_dout_s;

    // Credits, handshakes and counter next values; redirect dominates everything.
    always_comb begin
        credit_sum_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        req_valid_s  = rst_n && (credit_sum_s < DEPTH_W) && !bus.redirect_valid;
        req_fire_s   = req_valid_s && bus.mem_req_ready;
        push_s       = bus.mem_rsp_valid && (state_r == ST_RUN) && !bus.redirect_valid;
        pop_s        = !fifo_empty_s && bus.instr_ready && !bus.redirect_valid;
        rsp_one_s    = {{(CW-1){1'b0}}, bus.mem_rsp_valid};
        req_one_s    = {{(CW-1){1'b0}}, req_fire_s};
        outstanding_nxt_s = outstanding_r + req_one_s - rsp_one_s;
        if (bus.redirect_valid) begin
            drop_nxt_s = outstanding_r - rsp_one_s;
        end else if (bus.mem_rsp_valid && (state_r == ST_DRAIN)) begin
            drop_nxt_s = drop_cnt_r - CW'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Next-state: DRAIN while stale responses remain to be discarded.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (drop_nxt_s != {CW{1'b0}}) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drop_nxt_s == {CW{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PCs and in-flight counters; PCs wrap modulo 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= INITIAL_PC;
            head_pc_r     <= INITIAL_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc_r <= bus.redirect_pc;
                head_pc_r  <= bus.redirect_pc;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (pop_s) begin
                    head_pc_r <= head_pc_r + PC_STEP;
                end
            end
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_nxt_s;
        end
    end

    zipo_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.mem_rsp_data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    zipo_fetch_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .full  (fifo_full_s)
    );

    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_req_addr  = fetch_pc_r;
    assign bus.instr_valid   = !fifo_empty_s;
    assign bus.instr         = fifo_dout_s;
    assign bus.instr_pc      = head_pc_r;

`ifdef ZIPO_FETCH_PERF_EN
    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (bus.instr_ready && fifo_empty_s) begin
                perf_stall_cnt <= sat_inc32(perf_stall_cnt);
            end
            if (bus.redirect_valid) begin
                perf_flush_cnt <= sat_inc32(perf_flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_zipo_fetch.sv
// Directed bench for zipo_fetch: per-cycle vector table plus redirect/wrap sequences.
// The memory model answers in order after a fixed latency with a word derived from the address.
module tb_zipo_fetch;
    import zipo_fetch_pkg::*;

    localparam logic [63:0] P = ZF_INITIAL_PC;

    logic clk;
    logic rst_n;
    zipo_fetch_if bus ();
`ifdef ZIPO_FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    zipo_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master)
`ifdef ZIPO_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        int          lat;
        bit          mrdy;
        bit          irdy;
        bit          exp_rv;
        logic [63:0] exp_addr;
        bit          exp_iv;
        logic [63:0] exp_ipc;
    } vec_t;

    vec_t        vecs [20];
    int          nvec;
    int          nfail;
    int          cyc;
    int          lat;
    bit          sched_v [64];
    logic [31:0] sched_d [64];
    logic [63:0] req_log [$];
    logic [63:0] pc_log [$];
    logic [31:0] data_log [$];
    logic        s_rv, s_iv;
    logic [63:0] s_addr, s_ipc;
    logic [31:0] s_instr;

    function automatic logic [31:0] word(input logic [63:0] a);
        return {16'hC0DE ^ a[31:16], a[15:0]};
    endfunction

    task automatic setv(input int i, input bit r, input int l, input bit mr, input bit ir,
                        input bit erv, input logic [63:0] ea, input bit eiv, input logic [63:0] ep);
        vecs[i].do_rst = r;   vecs[i].lat = l;       vecs[i].mrdy = mr;   vecs[i].irdy = ir;
        vecs[i].exp_rv = erv; vecs[i].exp_addr = ea; vecs[i].exp_iv = eiv; vecs[i].exp_ipc = ep;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic reset_dut(input bit check);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0;
        bus.mem_req_ready = 1'b0;  bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = 32'd0;  bus.instr_ready = 1'b0;
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
        req_log.delete(); pc_log.delete(); data_log.delete();
        repeat (2) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
            chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
            chk("rst_instr", 64'(bus.instr), 64'd0);
            chk("rst_instr_pc", bus.instr_pc, P);
        end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock: present the scheduled response, sample at negedge, log handshakes.
    task automatic cycle();
        int slot;
        slot = cyc % 64;
        bus.mem_rsp_valid = sched_v[slot];
        bus.mem_rsp_data  = sched_d[slot];
        sched_v[slot] = 1'b0;
        @(negedge clk);
        s_rv = bus.mem_req_valid; s_addr = bus.mem_req_addr;
        s_iv = bus.instr_valid;   s_ipc = bus.instr_pc; s_instr = bus.instr;
        if (s_rv && bus.mem_req_ready) begin
            sched_v[(cyc + lat) % 64] = 1'b1;
            sched_d[(cyc + lat) % 64] = word(s_addr);
            req_log.push_back(s_addr);
        end
        if (s_iv && bus.instr_ready && !bus.redirect_valid) begin
            pc_log.push_back(s_ipc);
            data_log.push_back(s_instr);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_stream(input string name, input logic [63:0] base, input int min_n);
        bit bad;
        bad = (pc_log.size() < min_n);
        for (int i = 0; i < pc_log.size(); i++) begin
            if (pc_log[i] !== base + 64'(i) || data_log[i] !== word(pc_log[i])) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nfail++;
            $display("FAIL %s: got %0d instrs first pc %h, required >=%0d instrs from pc %h",
                     name, pc_log.size(), (pc_log.size() > 0) ? pc_log[0] : 64'hX, min_n, base);
        end
    endtask

    initial begin
        bit found;
        nvec = 0; nfail = 0; cyc = 0; lat = 1;
        rst_n = 1'b1;
        // Latency 1, everything ready: request every cycle, data two cycles later.
        setv(0,  1, 1, 1, 1, 1, P + 64'd0, 0, 64'd0);
        setv(1,  0, 1, 1, 1, 1, P + 64'd1, 0, 64'd0);
        setv(2,  0, 1, 1, 1, 1, P + 64'd2, 1, P + 64'd0);
        setv(3,  0, 1, 1, 1, 1, P + 64'd3, 1, P + 64'd1);
        setv(4,  0, 1, 1, 1, 1, P + 64'd4, 1, P + 64'd2);
        setv(5,  0, 1, 1, 1, 1, P + 64'd5, 1, P + 64'd3);
        setv(6,  0, 1, 1, 1, 1, P + 64'd6, 1, P + 64'd4);
        setv(7,  0, 1, 1, 1, 1, P + 64'd7, 1, P + 64'd5);
        // Core stalled: four requests fill the credits, then drain in order.
        setv(8,  1, 1, 1, 0, 1, P + 64'd0, 0, 64'd0);
        setv(9,  0, 1, 1, 0, 1, P + 64'd1, 0, 64'd0);
        setv(10, 0, 1, 1, 0, 1, P + 64'd2, 1, P + 64'd0);
        setv(11, 0, 1, 1, 0, 1, P + 64'd3, 1, P + 64'd0);
        setv(12, 0, 1, 1, 0, 0, 64'd0,     1, P + 64'd0);
        setv(13, 0, 1, 1, 0, 0, 64'd0,     1, P + 64'd0);
        setv(14, 0, 1, 1, 0, 0, 64'd0,     1, P + 64'd0);
        setv(15, 0, 1, 1, 1, 0, 64'd0,     1, P + 64'd0);
        setv(16, 0, 1, 1, 1, 1, P + 64'd4, 1, P + 64'd1);
        setv(17, 0, 1, 1, 1, 1, P + 64'd5, 1, P + 64'd2);
        setv(18, 0, 1, 1, 1, 1, P + 64'd6, 1, P + 64'd3);
        setv(19, 0, 1, 1, 1, 1, P + 64'd7, 1, P + 64'd4);

        reset_dut(1'b1);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].do_rst) reset_dut(1'b0);
            lat = vecs[i].lat;
            bus.mem_req_ready = vecs[i].mrdy;
            bus.instr_ready   = vecs[i].irdy;
            bus.redirect_valid = 1'b0;
            cycle();
            nvec++;
            if (s_rv !== vecs[i].exp_rv || (vecs[i].exp_rv && s_addr !== vecs[i].exp_addr) ||
                s_iv !== vecs[i].exp_iv ||
                (vecs[i].exp_iv && (s_ipc !== vecs[i].exp_ipc || s_instr !== word(vecs[i].exp_ipc)))) begin
                nfail++;
                $display("FAIL vec%0d: got rv=%b addr=%h iv=%b pc=%h instr=%h expected rv=%b addr=%h iv=%b pc=%h",
                         i, s_rv, s_addr, s_iv, s_ipc, s_instr,
                         vecs[i].exp_rv, vecs[i].exp_addr, vecs[i].exp_iv, vecs[i].exp_ipc);
            end
        end

        // Redirect with three requests in flight and no response that cycle.
        reset_dut(1'b0);
        lat = 4; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
        repeat (3) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h100;
        cycle();
        chk("t3_req_blocked", 64'(s_rv), 64'd0);
        bus.redirect_valid = 1'b0;
        cycle();
        chk("t3_first_req", s_rv ? s_addr : 64'hDEAD, 64'h100);
        repeat (10) cycle();
        chk("t3_req_after_stale", (req_log.size() > 3) ? req_log[3] : 64'hDEAD, 64'h100);
        chk_stream("t3_stream", 64'h100, 3);

        // Redirect coinciding with a response while two are outstanding.
        reset_dut(1'b0);
        lat = 2; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h180;
        chk("t4_rsp_in_redirect", 64'(sched_v[cyc % 64]), 64'd1);
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (10) cycle();
        chk_stream("t4_stream", 64'h180, 3);

        // Back-to-back redirects: the second one wins.
        reset_dut(1'b0);
        lat = 2; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h200;
        cycle();
        bus.redirect_pc = 64'h300;
        cycle();
        chk("t5_req_blocked", 64'(s_rv), 64'd0);
        bus.redirect_valid = 1'b0;
        repeat (10) cycle();
        found = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 64'h200) found = 1'b1;
        chk("t5_no_stale_req", 64'(found), 64'd0);
        chk_stream("t5_stream", 64'h300, 3);

        // PC wrap-around through 2^64.
        reset_dut(1'b0);
        lat = 1; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (8) cycle();
        chk_stream("t6_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 4);

`ifdef ZIPO_FETCH_PERF_EN
        // Five empty stall cycles, then two redirects.
        reset_dut(1'b0);
        lat = 1; bus.mem_req_ready = 1'b0; bus.instr_ready = 1'b1;
        repeat (5) cycle();
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h400;
        repeat (2) cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        chk("perf_stall", 64'(perf_stall_cnt), 64'd5);
        chk("perf_flush", 64'(perf_flush_cnt), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
